jtkiwi_shram_arb: RTL and testbench

JTKIWI_SHRAM_ARB -- requirements
Module: jtkiwi_shram_arb

---
 rtl/jtkiwi_shram_arb_if.sv | 15 +
 rtl/jtkiwi_shram_arb.sv | 142 ++++++++++++++
 tb/tb_jtkiwi_shram_arb.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtkiwi_shram_arb_if.sv
// Requester-side bus of the shared RAM arbiter: one instance per CPU.
// The master modport is the CPU view and the slave modport is the arbiter view.
interface jtkiwi_shram_arb_if #(
    parameter int AW = 13
);
    logic          cs;
    logic          rnw;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          busy;

    modport master (output cs, rnw, addr, din, input dout, busy);
    modport slave  (input cs, rnw, addr, din, output dout, busy);
endinterface

// File: rtl/jtkiwi_shram_arb.sv
// Two-port arbiter that lets the main CPU and the sound CPU share one
// single-port RAM with a one-cycle read latency.
// Optional feature: define JTKIWI_SHRAM_FIXPRIO_EN so that main always wins
// a tie. Without the macro, ties are resolved round robin.
//
// state | meaning
// IDLE  | waiting for a pending requester, grant made here
// ACC   | address/data on the RAM, write strobe for writes
// LAT   | RAM read data arrives, captured for reads, owner marked served
// REC   | RECOVERY idle cycles, no grant
module jtkiwi_shram_arb #(
    parameter int AW       = 13,
    parameter int RECOVERY = 0
) (
    input  logic                clk,
    input  logic                rst,
    jtkiwi_shram_arb_if.slave   main,
    jtkiwi_shram_arb_if.slave   snd,
    output logic [AW-1:0]       ram_addr,
    output logic [7:0]          ram_din,
    output logic                ram_we,
    input  logic [7:0]          ram_dout
);
    typedef enum logic [1:0] {IDLE, ACC, LAT, REC} state_t;

    localparam logic [1:0] REC_LOAD = (RECOVERY > 0) ? 2'(RECOVERY - 1) : 2'd0;

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       acc_rnw;
    logic       served_main;
    logic       served_snd;
    logic [1:0] rec_cnt;
    logic       pend_main;
    logic       pend_snd;
    logic       grant_any;
    logic       grant_snd;

    assign pend_main = main.cs & ~served_main;
    assign pend_snd  = snd.cs & ~served_snd;
    assign grant_any = pend_main | pend_snd;

    assign main.busy = pend_main;
    assign snd.busy  = pend_snd;

    // rst gates the strobe so an access interrupted in ACC never writes
    assign ram_we = (state == ACC) & ~acc_rnw & ~rst;

`ifdef JTKIWI_SHRAM_FIXPRIO_EN
    assign grant_snd = pend_snd & ~pend_main;
`else
    // set when snd should win the next tie; cleared so main wins after reset
    logic rr_snd;

    assign grant_snd = pend_snd & (~pend_main | rr_snd);

    // round-robin pointer: the requester just granted loses the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_snd <= 1'b0;
        end else if (state == IDLE && grant_any) begin
            rr_snd <= ~grant_snd;
        end
    end
`endif

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_any) state_nxt = ACC;
            ACC:  state_nxt = LAT;
            LAT:  state_nxt = (RECOVERY > 0) ? REC : IDLE;
            REC:  if (rec_cnt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register and recovery down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rec_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == LAT) begin
                rec_cnt <= REC_LOAD;
            end else if (state == REC && rec_cnt != 2'd0) begin
                rec_cnt <= rec_cnt - 2'd1;
            end
        end
    end

    // latch the winner's request so a cs falling mid-access cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= 1'b0;
            acc_rnw  <= 1'b1;
            ram_addr <= '0;
            ram_din  <= 8'd0;
        end else if (state == IDLE && grant_any) begin
            owner    <= grant_snd;
            acc_rnw  <= grant_snd ? snd.rnw  : main.rnw;
            ram_addr <= grant_snd ? snd.addr : main.addr;
            ram_din  <= grant_snd ? snd.din  : main.din;
        end
    end

    // read data capture; dout is only touched by reads of its own requester
    always_ff @(posedge clk) begin
        if (rst) begin
            main.dout <= 8'd0;
            snd.dout  <= 8'd0;
        end else if (state == LAT && acc_rnw) begin
            if (owner) begin
                snd.dout <= ram_dout;
            end else begin
                main.dout <= ram_dout;
            end
        end
    end

    // served flags: dropping cs always clears, completion sets only if cs held
    always_ff @(posedge clk) begin
        if (rst) begin
            served_main <= 1'b0;
            served_snd  <= 1'b0;
        end else begin
            if (!main.cs) begin
                served_main <= 1'b0;
            end else if (state == LAT && !owner) begin
                served_main <= 1'b1;
            end
            if (!snd.cs) begin
                served_snd <= 1'b0;
            end else if (state == LAT && owner) begin
                served_snd <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Self-checking bench for jtkiwi_shram_arb. A RECOVERY=0 instance carries the
// functional, arbitration, reset and randomized traffic checks; a RECOVERY=2
// instance checks grant spacing under continuous load. Expectations come from
// a shadow memory and the arbitration rules, not from the DUT.
module tb_jtkiwi_shram_arb;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtkiwi_shram_arb_if #(.AW(AW)) m_if ();
    jtkiwi_shram_arb_if #(.AW(AW)) s_if ();
    jtkiwi_shram_arb_if #(.AW(AW)) m2_if ();
    jtkiwi_shram_arb_if #(.AW(AW)) s2_if ();

    logic [AW-1:0] ram_addr, r2_addr;
    logic [7:0]    ram_din, r2_din, ram_dout;
    logic [7:0]    r2_dout = 8'd0;
    logic          ram_we, r2_we;

    jtkiwi_shram_arb #(.AW(AW), .RECOVERY(0)) u_dut (
        .clk(clk), .rst(rst), .main(m_if), .snd(s_if),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    jtkiwi_shram_arb #(.AW(AW), .RECOVERY(2)) u_dut_rec (
        .clk(clk), .rst(rst), .main(m2_if), .snd(s2_if),
        .ram_addr(r2_addr), .ram_din(r2_din), .ram_we(r2_we), .ram_dout(r2_dout)
    );

    logic [7:0] mem    [0:8191];
    logic [7:0] shadow [0:8191];
    logic [7:0] last_rd [2];
    bit         last_snd;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int we_cyc = 0;
    logic [AW-1:0] we_addr = '0;
    int r2_cyc [$];
    logic [AW-1:0] r2_adr [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt  = we_cnt + 1;
            we_cyc  = cyc;
            we_addr = ram_addr;
        end
        if (r2_we) begin
            r2_cyc.push_back(cyc);
            r2_adr.push_back(r2_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one CPU access: raise cs, wait for busy low, drop cs the cycle after
    task automatic do_acc(input bit who, input bit rnw, input logic [AW-1:0] addr,
                          input logic [7:0] din, output int start, output int lat,
                          output logic [7:0] dout);
        bit b;
        bit done;
        done = 1'b0;
        dout = 8'd0;
        @(posedge clk); #1;
        if (who) begin
            s_if.cs = 1'b1; s_if.rnw = rnw; s_if.addr = addr; s_if.din = din;
        end else begin
            m_if.cs = 1'b1; m_if.rnw = rnw; m_if.addr = addr; m_if.din = din;
        end
        start = cyc;
        lat = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            b = who ? s_if.busy : m_if.busy;
            if (!b) begin
                done = 1'b1;
                dout = who ? s_if.dout : m_if.dout;
            end else begin
                lat++;
                @(posedge clk); #1;
            end
        end
        chk("busy_release", 32'(done), 32'd1);
        last_snd = who;
        @(posedge clk); #1;
        if (who) s_if.cs = 1'b0;
        else     m_if.cs = 1'b0;
    endtask

    // simultaneous reads from both; the winner follows the arbitration rule
    task automatic pair(input logic [AW-1:0] am, input logic [AW-1:0] as);
        int st0, st1, l0, l1;
        logic [7:0] d0, d1;
        bit first_snd;
`ifdef JTKIWI_SHRAM_FIXPRIO_EN
        first_snd = 1'b0;
`else
        first_snd = ~last_snd;
`endif
        fork
            do_acc(1'b0, 1'b1, am, 8'd0, st0, l0, d0);
            do_acc(1'b1, 1'b1, as, 8'd0, st1, l1, d1);
        join
        chk("pair_main_lat", 32'(l0), first_snd ? 32'd6 : 32'd3);
        chk("pair_snd_lat",  32'(l1), first_snd ? 32'd3 : 32'd6);
        chk("pair_main_data", 32'(d0), 32'(shadow[am]));
        chk("pair_snd_data",  32'(d1), 32'(shadow[as]));
        last_rd[0] = shadow[am];
        last_rd[1] = shadow[as];
    endtask

    // randomized traffic from one requester on its own half of the address space
    task automatic rnd_stream(input bit who, input int n);
        int st, lat;
        logic [7:0] d, din;
        logic [AW-1:0] a;
        bit rnw;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            rnw = 1'($urandom_range(0, 1));
            a   = {12'($urandom_range(0, 4095)), who};
            din = 8'($urandom);
            do_acc(who, rnw, a, din, st, lat, d);
            chk("rnd_lat_in_range", 32'(lat >= 3 && lat <= 6), 32'd1);
            if (rnw) begin
                chk("rnd_rd_data", 32'(d), 32'(shadow[a]));
                last_rd[who] = shadow[a];
            end else begin
                shadow[a] = din;
                chk("rnd_wr_dout_hold", 32'(d), 32'(last_rd[who]));
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st, lat, w0;
        logic [7:0] d, v;
        bit mb, sb;

        for (int i = 0; i < 8192; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            shadow[i] = v;
        end
        mem[13'h0123] = 8'h5A;
        shadow[13'h0123] = 8'h5A;
        last_rd[0] = 8'd0;
        last_rd[1] = 8'd0;
        last_snd = 1'b1;
        {m_if.cs, m_if.rnw, m_if.addr, m_if.din} = '0;
        {s_if.cs, s_if.rnw, s_if.addr, s_if.din} = '0;
        {m2_if.cs, m2_if.rnw, m2_if.addr, m2_if.din} = '0;
        {s2_if.cs, s2_if.rnw, s2_if.addr, s2_if.din} = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_main_dout", 32'(m_if.dout), 32'd0);
        chk("rst_snd_dout", 32'(s_if.dout), 32'd0);
        chk("rst_busy", 32'({m_if.busy, s_if.busy}), 32'd0);

        // first tie after reset
        pair(13'h0200, 13'h0301);

        // main-only read with exact latency
        do_acc(1'b0, 1'b1, 13'h0123, 8'd0, st, lat, d);
        chk("main_rd_lat", 32'(lat), 32'd3);
        chk("main_rd_data", 32'(d), 32'h5A);
        last_rd[0] = 8'h5A;

        // sound-only write: one strobe in the cycle after cs rises
        w0 = we_cnt;
        do_acc(1'b1, 1'b0, 13'h1FFF, 8'hA5, st, lat, d);
        shadow[13'h1FFF] = 8'hA5;
        chk("snd_wr_lat", 32'(lat), 32'd3);
        chk("snd_wr_pulses", 32'(we_cnt - w0), 32'd1);
        chk("snd_wr_cycle", 32'(we_cyc), 32'(st + 1));
        chk("snd_wr_addr", 32'(we_addr), 32'h1FFF);
        chk("snd_wr_dout_hold", 32'(d), 32'(last_rd[1]));
        do_acc(1'b1, 1'b1, 13'h1FFF, 8'd0, st, lat, d);
        chk("snd_rdback", 32'(d), 32'hA5);
        last_rd[1] = 8'hA5;

        // back-to-back ties, then a lone main access, then another tie
        pair(13'h0010, 13'h0011);
        pair(13'h0020, 13'h0021);
        pair(13'h0030, 13'h0031);
        do_acc(1'b0, 1'b1, 13'h0040, 8'd0, st, lat, d);
        chk("lone_main_data", 32'(d), 32'(shadow[13'h0040]));
        last_rd[0] = shadow[13'h0040];
        pair(13'h0050, 13'h0051);

        // concurrent randomized traffic
        fork
            rnd_stream(1'b0, 30);
            rnd_stream(1'b1, 30);
        join

        // reset landing in ACC of a write
        w0 = we_cnt;
        @(posedge clk); #1;
        m_if.cs = 1'b1; m_if.rnw = 1'b0; m_if.addr = 13'h0456; m_if.din = ~shadow[13'h0456];
        @(posedge clk); #1;
        rst = 1'b1;
        m_if.cs = 1'b0;
        @(negedge clk);
        chk("rst_acc_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_we", 32'(ram_we), 32'd0);
        chk("rst_after_busy", 32'({m_if.busy, s_if.busy}), 32'd0);
        chk("rst_no_write", 32'(we_cnt - w0), 32'd0);
        last_snd = 1'b1;
        pair(13'h0456, 13'h0457);

        // RECOVERY=2 instance under continuous requests from both sides
        r2_cyc.delete();
        r2_adr.delete();
        @(posedge clk); #1;
        m2_if.rnw = 1'b0; m2_if.addr = 13'h00AA; m2_if.din = 8'h11;
        s2_if.rnw = 1'b0; s2_if.addr = 13'h0155; s2_if.din = 8'h22;
        m2_if.cs = 1'b1; s2_if.cs = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            mb = m2_if.busy;
            sb = s2_if.busy;
            @(posedge clk); #1;
            m2_if.cs = m2_if.cs ? mb : 1'b1;
            s2_if.cs = s2_if.cs ? sb : 1'b1;
        end
        m2_if.cs = 1'b0; s2_if.cs = 1'b0;
        chk("rec_enough_grants", 32'(r2_cyc.size() >= 10), 32'd1);
        if (r2_cyc.size() >= 10) begin
            for (int i = 1; i < 10; i++)
                chk("rec_grant_gap", 32'(r2_cyc[i] - r2_cyc[i-1]), 32'd5);
            for (int i = 0; i < 10; i++) begin
`ifdef JTKIWI_SHRAM_FIXPRIO_EN
                chk("rec_owner", 32'(r2_adr[i]), 32'h00AA);
`else
                chk("rec_owner", 32'(r2_adr[i]), (i % 2 == 0) ? 32'h00AA : 32'h0155);
`endif
            end
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
